clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_pkg.sv | 21 ++
 rtl/clock_ctrl_if.sv | 22 ++
 rtl/edge_det.sv | 19 +
 rtl/clock_ctrl.sv | 108 ++++++++++
 tb/tb_clock_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and limits for the digital clock.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } mode_e;

  localparam logic [5:0] MAX_HOUR = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  function automatic logic [5:0] wrap_inc(
    input logic [5:0] v,
    input logic [5:0] lim
  );
    return (v == lim) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Button inputs and time/mode outputs of the clock controller.
interface clock_ctrl_if;
  import clock_pkg::*;

  logic       btnMode;
  logic       btnInc;
  logic [4:0] digOra;
  logic [5:0] digMinut;
  logic [5:0] secunde;
  logic [1:0] mode;

  modport master (
    output btnMode, btnInc,
    input  digOra, digMinut, secunde, mode
  );

  modport slave (
    input  btnMode, btnInc,
    output digOra, digMinut, secunde, mode
  );

endinterface

// File: rtl/edge_det.sv
// Rising-edge press detector for a debounced button.
module edge_det (
  input  logic clk,
  input  logic reset_,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  // Reset high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) prev_q <= 1'b1;
    else         prev_q <= in;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// 24h clock with RUN / SET_H / SET_M modes and a 1 s prescaler.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       btnMode,
  input  logic       btnInc,
  output logic [4:0] digOra,
  output logic [5:0] digMinut,
  output logic [5:0] secunde,
  output logic [1:0] mode
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  mode_e         state_q, state_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          mode_p, inc_p;
  logic          tick;

  edge_det u_mode (
    .clk    (clk),
    .reset_ (reset_),
    .in     (btnMode),
    .pulse  (mode_p)
  );

  edge_det u_inc (
    .clk    (clk),
    .reset_ (reset_),
    .in     (btnInc),
    .pulse  (inc_p)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= RUN;
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    tick    = 1'b0;
    case (state_q)
      RUN: begin
        tick  = (pre_q == LAST);
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          sec_d = wrap_inc(sec_q, MAX_SEC);
          if (sec_q == MAX_SEC) begin
            min_d = wrap_inc(min_q, MAX_MIN);
            if (min_q == MAX_MIN)
              hr_d = 5'(wrap_inc({1'b0, hr_q}, MAX_HOUR));
          end
        end
        // Inc is ignored here; mode wins and restarts the second.
        if (mode_p) begin
          state_d = SET_H;
          sec_d   = '0;
          pre_d   = '0;
        end
      end
      SET_H: begin
        pre_d = '0;
        sec_d = '0;
        if (mode_p)     state_d = SET_M;
        else if (inc_p) hr_d = 5'(wrap_inc({1'b0, hr_q}, MAX_HOUR));
      end
      SET_M: begin
        pre_d = '0;
        sec_d = '0;
        if (mode_p)     state_d = RUN;
        else if (inc_p) min_d = wrap_inc(min_q, MAX_MIN);
      end
      default: begin
        state_d = RUN;
        pre_d   = '0;
      end
    endcase
  end

  assign digOra   = hr_q;
  assign digMinut = min_q;
  assign secunde  = sec_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl with DIV=4.
module tb_clock_ctrl;
  import clock_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset_ = 1'b0;

  clock_ctrl_if bus ();

  clock_ctrl #(.DIV(DIV)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .btnMode  (bus.btnMode),
    .btnInc   (bus.btnInc),
    .digOra   (bus.digOra),
    .digMinut (bus.digMinut),
    .secunde  (bus.secunde),
    .mode     (bus.mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    fld;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int fld);
    case (fld)
      0:       return 32'(bus.digOra);
      1:       return 32'(bus.digMinut);
      2:       return 32'(bus.secunde);
      default: return 32'(bus.mode);
    endcase
  endfunction

  task automatic push(input string tag, input int fld, input int val);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_all(input string tag,
                          input int h, input int m,
                          input int s, input int md);
    push({tag, ".hr"}, 0, h);
    push({tag, ".min"}, 1, m);
    push({tag, ".sec"}, 2, s);
    push({tag, ".mode"}, 3, md);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(e.fld), 32'(e.val));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    bus.btnMode = 1'b1;
    step(1);
    bus.btnMode = 1'b0;
  endtask

  task automatic press_inc();
    bus.btnInc = 1'b1;
    step(1);
    bus.btnInc = 1'b0;
    step(1);
  endtask

  initial begin
    bus.btnMode = 1'b0;
    bus.btnInc  = 1'b0;
    reset_      = 1'b0;
    step(2);
    push_all("rst", 0, 0, 0, 0);
    drain();
    reset_ = 1'b1;

    // Free run: 240 edges = 60 ticks.
    for (int n = 1; n <= 240; n++) begin
      step(1);
      if (n == 3)       push("first_tick.pre", 2, 0);
      if (n == 4)       push("first_tick", 2, 1);
      if (n % 40 == 0)  push("run.mode", 3, 0);
      if (n == 239)     push_all("run239", 0, 0, 59, 0);
      if (n == 240)     push_all("run240", 0, 1, 0, 0);
      drain();
    end

    press_mode();
    push_all("setH", 0, 1, 0, 1);
    drain();
    for (int i = 1; i <= 25; i++) begin
      press_inc();
      if (i == 23) push("hr23", 0, 23);
      if (i == 24) push("hr_wrap", 0, 0);
      if (i == 25) push_all("inc25", 1, 1, 0, 1);
      drain();
    end
    step(10);
    push("frozen.sec", 2, 0);
    drain();

    bus.btnInc = 1'b1;
    step(5);
    bus.btnInc = 1'b0;
    step(1);
    push("held_inc", 0, 2);
    drain();

    for (int i = 0; i < 21; i++) press_inc();
    push("hr_set23", 0, 23);
    press_mode();
    push("setM.mode", 3, 2);
    drain();
    step(1);
    for (int i = 0; i < 58; i++) press_inc();
    push("min59", 1, 59);
    drain();
    press_inc();
    push("min_wrap", 1, 0);
    push("min_wrap.hr", 0, 23);
    drain();
    for (int i = 0; i < 59; i++) press_inc();
    press_mode();
    push_all("preload", 23, 59, 0, 0);
    drain();

    for (int n = 1; n <= 240; n++) begin
      step(1);
      if (n == 3)   push("restart.pre", 2, 0);
      if (n == 4)   push("restart", 2, 1);
      if (n == 236) push_all("t235959", 23, 59, 59, 0);
      if (n == 239) push_all("t_hold", 23, 59, 59, 0);
      if (n == 240) push_all("midnight", 0, 0, 0, 0);
      drain();
    end

    bus.btnMode = 1'b1;
    bus.btnInc  = 1'b1;
    step(1);
    bus.btnMode = 1'b0;
    bus.btnInc  = 1'b0;
    push_all("both_run", 0, 0, 0, 1);
    drain();
    step(1);
    bus.btnMode = 1'b1;
    bus.btnInc  = 1'b1;
    step(1);
    bus.btnMode = 1'b0;
    bus.btnInc  = 1'b0;
    push("both_setH.hr", 0, 0);
    push("both_setH.mode", 3, 2);
    drain();
    step(1);

    press_mode();
    step(1);
    press_mode();
    push("reenter.mode", 3, 1);
    drain();
    step(1);
    for (int i = 0; i < 5; i++) press_inc();
    push("pre_rst.hr", 0, 5);
    drain();

    #2;
    reset_ = 1'b0;
    #1;
    push_all("async_rst", 0, 0, 0, 0);
    drain();
    bus.btnMode = 1'b1;
    step(3);
    reset_ = 1'b1;
    step(3);
    push("held_mode", 3, 0);
    drain();
    bus.btnMode = 1'b0;
    step(1);
    press_mode();
    push("after_held", 3, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
